// File: rtl/dado_pkg.sv
// Shared types, constants and the face-advance rule for the dice blocks.
package dado_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SLOW,
    HOLD
  } estado_t;

  localparam logic [2:0] CARA_BLANK = 3'd0;
  localparam logic [2:0] CARA_MIN   = 3'd1;
  localparam logic [2:0] CARA_MAX   = 3'd6;

  // 1->2->...->6->1; blank (0) and the unused code 7 both recover to 1.
  function automatic logic [2:0] siguiente_cara(logic [2:0] c);
    if (c >= CARA_MIN && c < CARA_MAX) begin
      return c + 3'd1;
    end
    return CARA_MIN;
  endfunction

endpackage

// File: rtl/control_dado_if.sv
// Button/face bundle between the dice controller and its user/decoder.
interface control_dado_if;
  import dado_pkg::*;

  logic       boton;
  logic [2:0] cara;
  logic       rodando;
  logic       valido;
  logic       listo;

  modport master (
    output boton,
    input  cara,
    input  rodando,
    input  valido,
    input  listo
  );

  modport slave (
    input  boton,
    output cara,
    output rodando,
    output valido,
    output listo
  );

endinterface

// File: rtl/contador_cara.sv
// Mod-6 face register: blank out of reset, steps 1..6 on each advance.
module contador_cara
  import dado_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_avanza,
  output logic [2:0] o_cara
);

  logic [2:0] r_cara;

  // Face register with synchronous reset to blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cara <= CARA_BLANK;
    end else if (i_avanza) begin
      r_cara <= siguiente_cara(r_cara);
    end
  end

  assign o_cara = r_cara;

endmodule

// File: rtl/control_dado.sv
// Roll sequencer: fast cycling while held, decelerating steps after release, then hold.
module control_dado
  import dado_pkg::*;
#(
  parameter int unsigned FAST_DIV   = 4,
  parameter int unsigned SLOW_STEPS = 3
) (
  input logic           clk,
  input logic           rst,
  control_dado_if.slave bus_if
);

  localparam int unsigned TIMER_W = $clog2(FAST_DIV * (SLOW_STEPS + 1));
  localparam int unsigned K_W     = $clog2(SLOW_STEPS + 1);

  estado_t              r_state, w_state_d;
  logic [TIMER_W-1:0]   r_timer, w_timer_d;
  logic [K_W-1:0]       r_k, w_k_d;
  logic                 r_listo, w_listo_d;
  logic                 r_rodando, r_valido;
  logic                 w_avanza;
  logic [2:0]           w_cara;
  logic                 w_fin_roll, w_fin_slow, w_ultimo_paso;

  // Interval ends compared at 32 bits so the slow limit never truncates.
  assign w_fin_roll    = (32'(r_timer) == FAST_DIV - 32'd1);
  assign w_fin_slow    = (32'(r_timer) == FAST_DIV * (32'(r_k) + 32'd2) - 32'd1);
  assign w_ultimo_paso = (32'(r_k) == SLOW_STEPS - 32'd1);

  // Next-state, timer/step counters and face-advance decode.
  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_k_d     = r_k;
    w_avanza  = 1'b0;
    w_listo_d = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus_if.boton) begin
          w_state_d = ROLL;
          w_timer_d = '0;
          w_avanza  = 1'b1;
        end
      end
      ROLL: begin
        if (!bus_if.boton) begin
          w_state_d = SLOW;
          w_timer_d = '0;
          w_k_d     = '0;
        end else if (w_fin_roll) begin
          w_timer_d = '0;
          w_avanza  = 1'b1;
        end else begin
          w_timer_d = r_timer + TIMER_W'(1);
        end
      end
      SLOW: begin
        // Re-roll wins over a step advance on the same edge.
        if (bus_if.boton) begin
          w_state_d = ROLL;
          w_timer_d = '0;
          w_k_d     = '0;
        end else if (w_fin_slow) begin
          w_timer_d = '0;
          w_k_d     = r_k + K_W'(1);
          w_avanza  = 1'b1;
          if (w_ultimo_paso) begin
            w_state_d = HOLD;
            w_listo_d = 1'b1;
          end
        end else begin
          w_timer_d = r_timer + TIMER_W'(1);
        end
      end
      HOLD: begin
        // Advance on exit so the old result is never the first rolling face.
        if (bus_if.boton) begin
          w_state_d = ROLL;
          w_timer_d = '0;
          w_avanza  = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_k       <= '0;
      r_listo   <= 1'b0;
      r_rodando <= 1'b0;
      r_valido  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_timer   <= w_timer_d;
      r_k       <= w_k_d;
      r_listo   <= w_listo_d;
      r_rodando <= (w_state_d == ROLL) || (w_state_d == SLOW);
      r_valido  <= (w_state_d == HOLD);
    end
  end

  contador_cara u_cara (
    .clk      (clk),
    .rst      (rst),
    .i_avanza (w_avanza),
    .o_cara   (w_cara)
  );

  assign bus_if.cara    = w_cara;
  assign bus_if.rodando = r_rodando;
  assign bus_if.valido  = r_valido;
  assign bus_if.listo   = r_listo;

endmodule

// File: doc/control_dado.md
# control_dado

Sequencing controller for the dice-face LED decoder. It turns a single push-button into a "roll": the face value cycles fast while the button is held, decelerates over a fixed number of steps after release, then freezes and flags the result. Its `cara` output drives the 3-bit input of the dice decoder directly; value 0 (blank) is shown only out of reset.

## Interface
Parameters:
- `FAST_DIV`, default 4: clock cycles per face step while rolling; must be ≥ 2.
- `SLOW_STEPS`, default 3: number of decelerating face steps after release; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `boton`  in  1  roll request (level); already synchronised/debounced upstream.
- `cara`  out  3  current face, 1..6; 0 = blank. Feeds the decoder input A.
- `rodando`  out  1  high in ROLL or SLOW.
- `valido`  out  1  high in HOLD: `cara` is a final result.
- `listo`  out  1  one-cycle pulse on entry to HOLD.

## Operation
- States: IDLE, ROLL, SLOW, HOLD.
- Reset (sampled `rst`=1): state IDLE, `cara`=0, `rodando`=0, `valido`=0, `listo`=0, `timer`=0, `k`=0. Reset overrides everything, including mid-roll.
- IDLE: `boton`=1 → ROLL, `cara`=1, `timer`=0.
- ROLL: `timer` increments each cycle. When `timer`==FAST_DIV-1, `cara` advances and `timer`=0. `boton`=0 → SLOW with `timer`=0, `k`=0, and `cara` unchanged on that edge.
- SLOW: step k lasts FAST_DIV*(k+2) cycles. When `timer`==FAST_DIV*(k+2)-1, `cara` advances, `timer`=0 and `k`++. When the advance completes step `k`==SLOW_STEPS-1, the next state is HOLD and `listo`=1 for that cycle.
- SLOW with `boton`=1 → ROLL, `timer`=0, `k`=0, `cara` unchanged. This is a re-roll and has priority over a step advance on the same edge.
- HOLD: `cara` frozen, `valido`=1. `boton`=1 → ROLL, `timer`=0, `cara` advances once on entry (the previous result is never reused as the first rolling face).
- Advance rule: 1→2→3→4→5→6→1. Values 0 and 7 never occur after the first press. An advance from 0 or 7 yields 1 (defensive).
- Widths:
  - `timer` is $clog2(FAST_DIV*(SLOW_STEPS+1)) bits.
  - `k` is $clog2(SLOW_STEPS+1) bits.
  - The interval compare uses full-width unsigned arithmetic, with no truncation.

## Timing
- All outputs are registered; there is no combinational path from `boton` to any output.
- Press latency: `boton` high sampled at edge N → `cara`=1 and `rodando`=1 after edge N.
- ROLL period: exactly FAST_DIV cycles per face, first advance FAST_DIV edges after entry.
- Release to HOLD: sum over k=0..SLOW_STEPS-1 of FAST_DIV*(k+2) cycles (36 with defaults).
- `listo` and `valido` rise on the same edge. `listo` falls on the next edge. `valido` falls on the edge that leaves HOLD.
- `boton` held continuously through HOLD is impossible, because entry requires a release. A press sampled in the same cycle that SLOW would complete → ROLL, with no HOLD and no `listo`.

## Structure
- Package `dado_pkg`:
  - state enum (IDLE, ROLL, SLOW, HOLD)
  - constants CARA_BLANK=0, CARA_MIN=1, CARA_MAX=6
  - function `siguiente_cara(logic [2:0])` implementing the advance rule.
- One sub-module, `contador_cara`: a mod-6 face register with `clk`, `rst`, advance enable and output `cara`. It is also reusable by future dice blocks.
- The FSM, `timer` and `k` live in `control_dado`. Top-level integration instantiates `control_dado` driving the dice decoder.

## Test plan
All scenarios use FAST_DIV=4, SLOW_STEPS=3.
- Reset with `boton`=0 for 10 cycles → `cara`=0, all flags 0, state IDLE throughout.
- `boton` high edges 1..25, then low → `cara`=1 at edge 1, advances at edges 5,9,13,17,21,25 (ending at 1). SLOW steps of 8,12,16 cycles give 2,3,4. `listo` pulses once, then `valido`=1 with `cara`=4.
- In HOLD (`cara`=4), assert `boton` for 1 cycle → `cara`=5 next edge, `valido`=0, `rodando`=1. Release follows the SLOW sequence to `cara`=2 in HOLD.
- Re-press during SLOW step k=1 → back to ROLL, `cara` unchanged that edge, `k` reset. After a later release, the full 36-cycle SLOW sequence runs again.
- Assert `rst` mid-ROLL and mid-SLOW → next edge `cara`=0, IDLE, no `listo`.
- Random `boton` for 10k cycles with a scoreboard → `cara` always in 1..6 after the first press, and exactly one `listo` per HOLD entry.
